// File: rtl/bpm_pkg.sv
// Shared tempo limits, state encodings and helpers
// for the beat generator and energy detector.
package bpm_pkg;

  localparam int unsigned DEF_MIN_BPM = 30;
  localparam int unsigned DEF_MAX_BPM = 240;

  typedef enum logic {
    IDLE,
    DIV
  } ctrl_state_t;

  typedef enum logic {
    STOPPED,
    RUNNING
  } gen_state_t;

  function automatic logic [63:0] ticks_per_minute(
    input logic [63:0] clock_freq
  );
    return clock_freq * 64'd60;
  endfunction

endpackage

// File: rtl/bpm_serial_divider.sv
// 32-bit restoring divider, one quotient bit per cycle.
// quotient carries the final result during the done cycle.
module bpm_serial_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done    = 1'b0;
    shifted = '0;
    trial   = '0;
    if (busy_q) begin
      shifted = {rem_q, quo_q[31]};
      trial   = shifted - {1'b0, dvs_q};
      // borrow out of bit 32 means the divisor did not fit
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign quotient = quo_d;

endmodule

// File: rtl/bpm_beat_generator.sv
// Metronome: converts a BPM value to a beat period and emits
// beat pulses, bar position, downbeat flag and click envelope.
module bpm_beat_generator
  import bpm_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ    = 18_432_000,
  parameter int unsigned BPM_WIDTH     = 16,
  parameter int unsigned MIN_BPM       = DEF_MIN_BPM,
  parameter int unsigned MAX_BPM       = DEF_MAX_BPM,
  parameter int unsigned BEATS_PER_BAR = 4,
  parameter int unsigned CLICK_CYCLES  = 1843
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [BPM_WIDTH-1:0]             bpm_val,
  input  logic                             bpm_load,
  input  logic                             sync,
  output logic                             busy,
  output logic                             bpm_reject,
  output logic [BPM_WIDTH-1:0]             bpm_active,
  output logic [31:0]                      interval_out,
  output logic                             beat_pulse,
  output logic                             downbeat,
  output logic [$clog2(BEATS_PER_BAR)-1:0] beat_index,
  output logic                             click
);

  localparam int unsigned IDX_W = $clog2(BEATS_PER_BAR);
  localparam int unsigned CLK_W = $clog2(CLICK_CYCLES + 1);
  localparam logic [63:0] TPM64 = ticks_per_minute(64'(CLOCK_FREQ));
  localparam logic [31:0] TPM   = TPM64[31:0];
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_PER_BAR - 1);
  localparam logic [BPM_WIDTH-1:0] LO = BPM_WIDTH'(MIN_BPM);
  localparam logic [BPM_WIDTH-1:0] HI = BPM_WIDTH'(MAX_BPM);
  localparam logic [CLK_W-1:0] CLICK_LOAD = CLK_W'(CLICK_CYCLES);

  if (TPM64 > 64'h0000_0000_FFFF_FFFF) begin : g_tpm_chk
    $error("CLOCK_FREQ*60 does not fit in 32 bits");
  end
  if (BEATS_PER_BAR < 2) begin : g_bar_chk
    $error("BEATS_PER_BAR must be at least 2");
  end

  ctrl_state_t          ctrl_q, ctrl_d;
  gen_state_t           gen_q, gen_d;
  logic [BPM_WIDTH-1:0] bpm_lat_q, bpm_lat_d;
  logic [BPM_WIDTH-1:0] active_q, active_d;
  logic [31:0]          interval_q, interval_d;
  logic [31:0]          phase_q, phase_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CLK_W-1:0]     click_q, click_d;
  logic                 beat_q, beat_d;
  logic                 reject_q, reject_d;

  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quo;
  logic        stop;
  logic        ld_zero;
  logic        ld_ok;
  logic [31:0] interval_ref;

  bpm_serial_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (TPM),
    .divisor  (32'(bpm_lat_d)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign ld_zero = (bpm_val == '0);
  assign ld_ok   = (bpm_val >= LO) && (bpm_val <= HI);

  always_comb begin
    ctrl_d     = ctrl_q;
    bpm_lat_d  = bpm_lat_q;
    active_d   = active_q;
    interval_d = interval_q;
    reject_d   = 1'b0;
    div_start  = 1'b0;
    stop       = 1'b0;
    case (ctrl_q)
      IDLE: begin
        if (bpm_load) begin
          if (ld_zero) begin
            stop     = 1'b1;
            active_d = '0;
          end else if (!ld_ok) begin
            reject_d = 1'b1;
          end else begin
            bpm_lat_d = bpm_val;
            div_start = 1'b1;
            ctrl_d    = DIV;
          end
        end
      end
      DIV: begin
        reject_d = bpm_load;
        if (div_done) begin
          ctrl_d     = IDLE;
          interval_d = div_quo;
          active_d   = bpm_lat_q;
        end
      end
    endcase
  end

  // a completing divide is the wrap reference in its own cycle
  assign interval_ref = div_done ? div_quo : interval_q;

  always_comb begin
    gen_d   = gen_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    beat_d  = 1'b0;
    click_d = (click_q != '0) ? click_q - CLK_W'(1) : click_q;
    if (stop) begin
      gen_d   = STOPPED;
      phase_d = '0;
      idx_d   = '0;
      click_d = '0;
    end else begin
      case (gen_q)
        STOPPED: begin
          if (div_done) begin
            gen_d   = RUNNING;
            phase_d = '0;
            idx_d   = '0;
            beat_d  = 1'b1;
          end
        end
        RUNNING: begin
          if (enable) begin
            if (sync) begin
              phase_d = '0;
              idx_d   = '0;
              beat_d  = 1'b1;
            end else if (phase_q >= interval_ref - 32'd1) begin
              phase_d = '0;
              idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
              beat_d  = 1'b1;
            end else begin
              phase_d = phase_q + 32'd1;
            end
          end
        end
      endcase
    end
    if (beat_d) begin
      click_d = CLICK_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= IDLE;
      gen_q      <= STOPPED;
      bpm_lat_q  <= '0;
      active_q   <= '0;
      interval_q <= '0;
      phase_q    <= '0;
      idx_q      <= '0;
      click_q    <= '0;
      beat_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      gen_q      <= gen_d;
      bpm_lat_q  <= bpm_lat_d;
      active_q   <= active_d;
      interval_q <= interval_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      click_q    <= click_d;
      beat_q     <= beat_d;
      reject_q   <= reject_d;
    end
  end

  assign busy         = div_busy;
  assign bpm_reject   = reject_q;
  assign bpm_active   = active_q;
  assign interval_out = interval_q;
  assign beat_pulse   = beat_q;
  assign downbeat     = beat_q && (idx_q == '0);
  assign beat_index   = idx_q;
  assign click        = (click_q != '0);

endmodule
